// File: rtl/traffic_pkg.sv
// Shared types for the wind-pattern light path: the wind code and the debounce state.
package traffic_pkg;

  typedef enum logic [1:0] {
    CALM = 2'b00,
    R2L  = 2'b01,
    L2R  = 2'b10,
    BAD  = 2'b11
  } wind_t;

  typedef enum logic {
    STABLE,
    SETTLING
  } deb_state_t;

endpackage

// File: rtl/wind_input_conditioner_step_divider.sv
// Free-running step pulse generator; restart realigns the period to a new wind pattern.
module step_divider #(
  parameter int unsigned STEP_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic step
);

  localparam int unsigned DW = $clog2(STEP_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(STEP_DIV - 1);

  logic [DW-1:0] div;
  logic [DW-1:0] div_next;

  always_comb begin
    div_next = div + 1'b1;
    if (restart || div == DIV_MAX) begin
      div_next = '0;
    end
  end

  // step is registered from div_next so it is high exactly while div holds DIV_MAX
  always_ff @(posedge clk) begin
    if (reset) begin
      div  <= '0;
      step <= 1'b0;
    end else begin
      div  <= div_next;
      step <= (div_next == DIV_MAX);
    end
  end

endmodule

// File: rtl/wind_input_conditioner.sv
// Switch synchroniser, debouncer and legality filter producing the wind code and step enable.
module wind_input_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STEP_DIV        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_raw,
  output logic [1:0] w,
  output logic       step,
  output logic       w_changed,
  output logic       illegal
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  s1;
  logic [1:0]  s2;
  wind_t       cand;
  wind_t       w_q;
  deb_state_t  state;
  logic [CW-1:0] cnt;
  logic        update;

  assign w = w_q;

  // A new legal value is taken only once the candidate is stable and s2 still agrees with it.
  assign update = (state == STABLE) && (s2 == cand) && (cand != w_q) && (cand != BAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      cand      <= CALM;
      cnt       <= CNT_MAX;
      state     <= STABLE;
      w_q       <= CALM;
      w_changed <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      s1        <= sw_raw;
      s2        <= s1;
      w_changed <= 1'b0;
      if (s2 != cand) begin
        cand    <= wind_t'(s2);
        cnt     <= '0;
        state   <= SETTLING;
        illegal <= 1'b0;
      end else if (state == SETTLING) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_MAX - 1'b1) begin
          state   <= STABLE;
          illegal <= (cand == BAD);
        end
      end else if (update) begin
        w_q       <= cand;
        w_changed <= 1'b1;
      end
    end
  end

  step_divider #(
    .STEP_DIV(STEP_DIV)
  ) u_step_divider (
    .clk    (clk),
    .reset  (reset),
    .restart(update),
    .step   (step)
  );

endmodule
